// File: rtl/ram_stream_loader_pkg.sv
// Shared memory-map constants and loader state type.
//   RAM_BASE_ADDR   : byte address of data RAM word 0
//   RAM_DEPTH_WORDS : data RAM capacity in 32-bit words
//   loader_state_t  : loader FSM state encoding
package ram_stream_loader_pkg;

    localparam logic [31:0] RAM_BASE_ADDR   = 32'h0000_1000;
    localparam int unsigned RAM_DEPTH_WORDS = 100;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/ram_stream_loader_if.sv
// Byte-stream input and RAM write bus of the loader.
//   byte_valid/byte_data/byte_last/byte_ready : valid/ready byte stream into the loader
//   MemWrite/A/WriteData                      : RAM write port driven by the loader
// Modports:
//   slave  : the loader (consumes the stream, drives the RAM bus)
//   master : the environment (produces the stream, observes the RAM bus)
interface ram_stream_loader_if;

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_ready;
    logic        MemWrite;
    logic [31:0] A;
    logic [31:0] WriteData;

    modport slave (
        input  byte_valid,
        input  byte_data,
        input  byte_last,
        output byte_ready,
        output MemWrite,
        output A,
        output WriteData
    );

    modport master (
        output byte_valid,
        output byte_data,
        output byte_last,
        input  byte_ready,
        input  MemWrite,
        input  A,
        input  WriteData
    );

endinterface

// File: rtl/ram_stream_loader_byte_packer.sv
// Packs accepted bytes into a 32-bit little-endian word.
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : drop any partially packed word
//   accept     : byte_data is taken this cycle
//   byte_data  : incoming byte
//   byte_last  : incoming byte is the final one of the stream
//   word_ready : the byte taken this cycle completes a word (4th byte or last)
//   word       : completed word including this cycle's byte, upper bytes zero
module ram_stream_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        word_ready,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt_q;
    logic [31:0] shift_q;

    // The word is formed combinationally so the top can register it in the same
    // cycle the final byte arrives; bytes above byte_cnt are still zero in shift_q.
    always_comb begin
        word       = shift_q | (32'(byte_data) << {byte_cnt_q, 3'b000});
        word_ready = accept && ((byte_cnt_q == 2'd3) || byte_last);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_q <= 2'd0;
            shift_q    <= 32'd0;
        end else if (clear || word_ready) begin
            byte_cnt_q <= 2'd0;
            shift_q    <= 32'd0;
        end else if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            shift_q    <= word;
        end
    end

endmodule

// File: rtl/ram_stream_loader.sv
// Preloads the data RAM from a byte stream: packs bytes into little-endian words and
// writes them to consecutive word addresses starting at BASE_ADDR.
//   clk, rst      : clock, asynchronous active-low reset
//   start         : begin a new load (ignored while busy)
//   bus           : byte stream in, RAM write bus out (slave side)
//   busy          : load in progress
//   done          : load finished, held until the next start
//   overflow      : RAM filled before the last byte was seen
//   words_written : words written during the current load
module ram_stream_loader
    import ram_stream_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = RAM_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = RAM_DEPTH_WORDS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    ram_stream_loader_if.slave                 bus,
    output logic                               busy,
    output logic                               done,
    output logic                               overflow,
    output logic [$clog2(DEPTH_WORDS+1)-1:0]   words_written
);

    localparam int unsigned CntW = $clog2(DEPTH_WORDS + 1);

    loader_state_t state_q, state_d;
    // Word index and words-written count are always equal, so one counter serves both.
    logic [CntW-1:0] words_q, words_d;
    logic            last_q, last_d;
    logic            ovf_q, ovf_d;
    logic            mem_write_q, mem_write_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;

    logic        accept;
    logic        clear;
    logic        word_ready;
    logic [31:0] word;

    assign bus.byte_ready = (state_q == COLLECT);
    assign accept         = bus.byte_valid && bus.byte_ready;

    ram_stream_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .accept     (accept),
        .byte_data  (bus.byte_data),
        .byte_last  (bus.byte_last),
        .word_ready (word_ready),
        .word       (word)
    );

    always_comb begin
        state_d     = state_q;
        words_d     = words_q;
        last_d      = last_q;
        ovf_d       = ovf_q;
        mem_write_d = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        clear       = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = COLLECT;
                    words_d = '0;
                    last_d  = 1'b0;
                    ovf_d   = 1'b0;
                    clear   = 1'b1;
                end
            end
            COLLECT: begin
                if (word_ready) begin
                    state_d     = WRITE;
                    mem_write_d = 1'b1;
                    addr_d      = BASE_ADDR + (32'(words_q) << 2);
                    wdata_d     = word;
                    last_d      = bus.byte_last;
                end
            end
            WRITE: begin
                words_d = words_q + 1'b1;
                if (last_q) begin
                    state_d = DONE;
                end else if (words_q == CntW'(DEPTH_WORDS - 1)) begin
                    state_d = DONE;
                    ovf_d   = 1'b1;
                end else begin
                    state_d = COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            words_q     <= '0;
            last_q      <= 1'b0;
            ovf_q       <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= BASE_ADDR;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            words_q     <= words_d;
            last_q      <= last_d;
            ovf_q       <= ovf_d;
            mem_write_q <= mem_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign bus.MemWrite  = mem_write_q;
    assign bus.A         = addr_q;
    assign bus.WriteData = wdata_q;
    assign busy          = (state_q == COLLECT) || (state_q == WRITE);
    assign done          = (state_q == DONE);
    assign overflow      = ovf_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_ram_stream_loader.sv
module tb_ram_stream_loader;
    import ram_stream_loader_pkg::*;

    localparam int unsigned DEPTH = RAM_DEPTH_WORDS;
    localparam int unsigned CNTW  = $clog2(DEPTH + 1);

    logic            clk;
    logic            rst;
    logic            start;
    logic            busy;
    logic            done;
    logic            overflow;
    logic [CNTW-1:0] words_written;

    ram_stream_loader_if bus ();

    ram_stream_loader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: bytes go into a queue; a word is complete on the 4th byte or the
    // last byte and must appear on the RAM bus the following cycle.
    bit          m_active, m_pend, m_fin, m_ovf, m_lastseen;
    int          m_words;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_word, m_addr;

    logic [31:0] log_a[$];
    logic [31:0] log_d[$];

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_memwrite", 32'(bus.MemWrite), 32'd0);
            check("rst_a", bus.A, RAM_BASE_ADDR);
            check("rst_wdata", bus.WriteData, 32'd0);
            check("rst_flags", {29'd0, busy, done, overflow}, 32'd0);
            check("rst_ready", 32'(bus.byte_ready), 32'd0);
            check("rst_words", 32'(words_written), 32'd0);
            m_active = 0; m_pend = 0; m_fin = 0; m_ovf = 0; m_lastseen = 0; m_words = 0;
            m_bytes.delete();
        end else begin
            bit exp_ready;
            bit was_idle;
            exp_ready = m_active && !m_pend;
            was_idle  = !m_active;
            check("memwrite", 32'(bus.MemWrite), 32'(m_pend));
            if (m_pend) begin
                check("write_a", bus.A, m_addr);
                check("write_data", bus.WriteData, m_word);
            end
            if (bus.MemWrite) begin
                log_a.push_back(bus.A);
                log_d.push_back(bus.WriteData);
            end
            check("byte_ready", 32'(bus.byte_ready), 32'(exp_ready));
            check("busy", 32'(busy), 32'(m_active));
            check("done", 32'(done), 32'(m_fin));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("words_written", 32'(words_written), 32'(m_words));

            if (m_pend) begin
                m_pend = 0;
                m_words++;
                if (m_lastseen) begin
                    m_active = 0; m_fin = 1;
                end else if (m_words == DEPTH) begin
                    m_active = 0; m_fin = 1; m_ovf = 1;
                end
            end else if (exp_ready && bus.byte_valid) begin
                m_bytes.push_back(bus.byte_data);
                if (bus.byte_last || m_bytes.size() == 4) begin
                    m_word = 32'd0;
                    foreach (m_bytes[k]) m_word |= 32'(m_bytes[k]) << (8 * k);
                    m_addr     = RAM_BASE_ADDR + 32'(4 * m_words);
                    m_pend     = 1;
                    m_lastseen = bus.byte_last;
                    m_bytes.delete();
                end
            end
            if (start && was_idle) begin
                m_active = 1; m_fin = 0; m_ovf = 0; m_words = 0; m_lastseen = 0;
                m_bytes.delete();
            end
        end
    end

    logic [7:0] tx[$];

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents every byte in tx, idling idle_cycles before each one.
    task automatic send(input bit last_on_final, input int idle_cycles);
        for (int i = 0; i < tx.size(); i++) begin
            bit got;
            int n;
            bus.byte_valid = 1'b0;
            repeat (idle_cycles) begin
                @(posedge clk); #1;
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = tx[i];
            bus.byte_last  = last_on_final && (i == tx.size() - 1);
            got = 0;
            n   = 0;
            while (!got && n < 200) begin
                @(negedge clk);
                if (bus.byte_ready) got = 1;
                @(posedge clk); #1;
                n++;
            end
            if (!got) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=byte %0d not taken required=taken", i);
                bus.byte_valid = 1'b0;
                bus.byte_last  = 1'b0;
                return;
            end
        end
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic new_load();
        log_a.delete();
        log_d.delete();
        pulse_start();
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;
        bus.byte_last  = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("idle_a", bus.A, 32'h1000);
        check("idle_done", 32'(done), 32'd0);

        // 1: two full words
        new_load();
        tx.delete();
        for (int i = 1; i <= 8; i++) tx.push_back(8'(i));
        send(1'b1, 0);
        wait_done();
        check("t1_nwrites", 32'(log_a.size()), 32'd2);
        if (log_a.size() == 2) begin
            check("t1_a0", log_a[0], 32'h1000);
            check("t1_d0", log_d[0], 32'h0403_0201);
            check("t1_a1", log_a[1], 32'h1004);
            check("t1_d1", log_d[1], 32'h0807_0605);
        end
        check("t1_words", 32'(words_written), 32'd2);
        check("t1_ovf", 32'(overflow), 32'd0);

        // 2: partial word, zero padded
        new_load();
        tx = '{8'hAA, 8'hBB, 8'hCC};
        send(1'b1, 0);
        wait_done();
        check("t2_nwrites", 32'(log_a.size()), 32'd1);
        if (log_a.size() == 1) begin
            check("t2_a0", log_a[0], 32'h1000);
            check("t2_d0", log_d[0], 32'h00CC_BBAA);
        end

        // 3: RAM fills without last; further bytes refused
        new_load();
        tx.delete();
        for (int i = 0; i < 400; i++) tx.push_back(8'($urandom));
        send(1'b0, 0);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h5A;
        repeat (8) begin
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b0;
        wait_done();
        check("t3_nwrites", 32'(log_a.size()), 32'd100);
        if (log_a.size() == 100) check("t3_last_a", log_a[99], 32'h118C);
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_ready", 32'(bus.byte_ready), 32'd0);

        // 4: last on the final byte that fits
        new_load();
        send(1'b1, 0);
        wait_done();
        check("t4_nwrites", 32'(log_a.size()), 32'd100);
        check("t4_ovf", 32'(overflow), 32'd0);
        check("t4_words", 32'(words_written), 32'd100);

        // 5: sparse valid gives the same RAM contents as test 1
        new_load();
        tx.delete();
        for (int i = 1; i <= 8; i++) tx.push_back(8'(i));
        send(1'b1, 2);
        wait_done();
        check("t5_nwrites", 32'(log_a.size()), 32'd2);
        if (log_a.size() == 2) begin
            check("t5_d0", log_d[0], 32'h0403_0201);
            check("t5_d1", log_d[1], 32'h0807_0605);
        end

        // Random streams
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 24);
            new_load();
            tx.delete();
            for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
            send(1'b1, $urandom_range(0, 2));
            wait_done();
            check("rand_nwrites", 32'(log_a.size()), 32'((n + 3) / 4));
        end

        // 6: reset mid-load, then reload from word 0
        new_load();
        tx.delete();
        for (int i = 0; i < 6; i++) tx.push_back(8'(8'h10 + i));
        send(1'b0, 0);
        rst = 1'b0;
        #1;
        check("t6_memwrite", 32'(bus.MemWrite), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_words", 32'(words_written), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        new_load();
        tx = '{8'h21, 8'h22, 8'h23, 8'h24};
        send(1'b1, 0);
        wait_done();
        check("t6_nwrites", 32'(log_a.size()), 32'd1);
        if (log_a.size() == 1) begin
            check("t6_a0", log_a[0], 32'h1000);
            check("t6_d0", log_d[0], 32'h2423_2221);
        end
        check("t6_words_after", 32'(words_written), 32'd1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
